// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - state encoding, default parameters and sizing helpers for reset_sequencer
package reset_sequencer_pkg;

   localparam int DEF_N_CHANNELS         = 3;
   localparam int DEF_LOCK_STABLE_CYCLES = 8;
   localparam int DEF_HOLD_CYCLES        = 16;
   localparam int DEF_STAGGER_CYCLES     = 4;
   localparam int DEF_COUNT_W            = 8;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_STABLE    = 3'd1,
      ST_HOLD      = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4
   } seq_state_t;

   // Largest of three cycle counts; one shared counter serves every timed phase.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Bits needed to hold the values 0 .. max_value-1, never less than one.
   function automatic int width_for(input int max_value);
      return (max_value > 1) ? $clog2(max_value) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_data,
   output logic o_data
);

   logic meta;

   // Capture the asynchronous level, then give it a full cycle to settle.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         meta   <= 1'b0;
         o_data <= 1'b0;
      end else begin
         meta   <= i_data;
         o_data <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - lock-qualified staggered reset release; RESET_SEQUENCER_LOCK_SYNC_EN adds a 2-flop lock synchroniser
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int N_CHANNELS         = DEF_N_CHANNELS,
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int HOLD_CYCLES        = DEF_HOLD_CYCLES,
   parameter int STAGGER_CYCLES     = DEF_STAGGER_CYCLES,
   parameter int COUNT_W            = DEF_COUNT_W
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_locked,
   input  logic                  i_soft_reset,
   output logic [N_CHANNELS-1:0] o_reset,
   output logic                  o_ready,
   output logic [COUNT_W-1:0]    o_lock_loss_count
);

   localparam int CNT_W = width_for(max3(LOCK_STABLE_CYCLES, HOLD_CYCLES, STAGGER_CYCLES));
   localparam int IDX_W = width_for(N_CHANNELS);

   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_CHANNELS - 1);

   seq_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic              lock_s;
   logic              lock_lost;
   logic              soft_restart;

`ifdef RESET_SEQUENCER_LOCK_SYNC_EN
   sync_2ff u_lock_sync (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_data  (i_locked),
      .o_data  (lock_s)
   );
`else
   assign lock_s = i_locked;
`endif

   // Lock loss only matters once the hold has begun; a soft restart only once release has begun.
   always_comb begin
      lock_lost    = 1'b0;
      soft_restart = 1'b0;
      if (state == ST_HOLD || state == ST_RELEASE || state == ST_RUN) begin
         lock_lost = !lock_s;
      end
      if (state == ST_RELEASE || state == ST_RUN) begin
         soft_restart = i_soft_reset && lock_s;
      end
   end

   // Sequencer: qualify lock, hold every channel, then release channels one by one.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state             <= ST_WAIT_LOCK;
         cnt               <= '0;
         idx               <= '0;
         o_reset           <= '1;
         o_ready           <= 1'b0;
         o_lock_loss_count <= '0;
      end else if (lock_lost) begin
         // Lock loss wins over a simultaneous soft restart.
         state   <= ST_WAIT_LOCK;
         cnt     <= '0;
         idx     <= '0;
         o_reset <= '1;
         o_ready <= 1'b0;
         if (o_lock_loss_count != '1) begin
            o_lock_loss_count <= o_lock_loss_count + COUNT_W'(1);
         end
      end else if (soft_restart) begin
         state   <= ST_HOLD;
         cnt     <= '0;
         idx     <= '0;
         o_reset <= '1;
         o_ready <= 1'b0;
      end else begin
         case (state)
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state <= ST_STABLE;
                  cnt   <= '0;
               end
            end
            ST_STABLE: begin
               // A glitch before lock has proven stable is not counted as a loss.
               if (!lock_s) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state <= ST_HOLD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state <= ST_RELEASE;
                  cnt   <= '0;
                  idx   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (cnt == STAGGER_LAST) begin
                  cnt <= '0;
                  // Bits 0..idx-1 are already clear, so a left shift clears exactly bit idx.
                  o_reset <= o_reset << 1;
                  if (idx == IDX_LAST) begin
                     state   <= ST_RUN;
                     o_ready <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
            end
            default: begin
               state   <= ST_WAIT_LOCK;
               cnt     <= '0;
               idx     <= '0;
               o_reset <= '1;
               o_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
